switch_mcu_ex_seq: RTL and testbench
====================================

SWITCH_MCU_EX_SEQ -- requirements
Module: switch_mcu_ex_seq

Interface
REQ-001 SHALL have parameter LAST_CYCLE, default 4, final execute cycle number (legal range 2..14).
REQ-002 SHALL have parameter RETIRE_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have port in_clk, input, 1, clock; all state changes on its rising edge.
REQ-004 SHALL have port in_rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port in_start, input, 1, decoded-instruction-valid pulse from the decoder.
REQ-006 SHALL have port in_type, input, 3, instruction class: 0=R-type, 1=I-type, 2=load, 3=store, 4=branch; 5..7 illegal.
REQ-007 SHALL have port in_stall, input, 1, memory/bus wait; freezes the cycle counter.
REQ-008 SHALL have port in_flush, input, 1, synchronous abort of the current instruction.
REQ-009 SHALL have port out_cycle_cnt, output, 4, cycle number broadcast to all execute units.
REQ-010 SHALL have port out_en, output, 5, one-hot execute-unit enable, bit index = in_type.
REQ-011 SHALL have port out_busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port out_done, output, 1, one-cycle pulse on instruction retire.
REQ-013 SHALL have port out_illegal, output, 1, one-cycle pulse on an illegal in_type at start.
REQ-014 SHALL have port out_retired, output, RETIRE_W, count of retired instructions.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE + in_start + legal in_type: latch type, next cycle state=RUN, out_cycle_cnt=1, out_en=1<<type.
REQ-017 IDLE + in_start + illegal in_type: out_illegal=1 for one cycle, remain IDLE, out_en stays 0.
REQ-018 in_start while not IDLE: ignored; no error pulse.
REQ-019 RUN, in_stall=0, cnt<LAST_CYCLE: cnt increments by 1 each cycle.
REQ-020 RUN, in_stall=1: cnt and out_en hold their values.
REQ-021 RUN, cnt==LAST_CYCLE, in_stall=0: next cycle state=DONE, cnt=0, out_en held, out_done=1.
REQ-022 DONE: unconditionally next cycle IDLE, out_en=0, cnt=0, out_done=0; out_retired increments by 1.
REQ-023 Retire-to-restart: in_start is sampled only in IDLE, so the minimum instruction period is LAST_CYCLE+2 cycles.
REQ-024 out_retired SHALL wrap from all-ones to 0 without any flag.
REQ-025 in_flush=1 in any state: next cycle IDLE, cnt=0, out_en=0, out_done=0; out_retired unchanged.
REQ-026 in_flush has priority over in_stall, in_start and retire, including flush in the same cycle as cnt==LAST_CYCLE.
REQ-027 out_en SHALL never have more than one bit set.
REQ-028 out_en SHALL be nonzero only in RUN and DONE.

Reset
REQ-029 While in_rst=0: state=IDLE; out_cycle_cnt=0, out_en=0, out_busy=0, out_done=0, out_illegal=0, out_retired=0.
REQ-030 Reset asserted mid-RUN SHALL abort the instruction immediately (asynchronously) with no done pulse.
REQ-031 First in_start is accepted on the first rising edge after in_rst deasserts.

Structure
REQ-032 The type encodings, FSM state encodings and the default LAST_CYCLE SHALL live in shared package switch_mcu_pkg.
REQ-033 Single module; no sub-module. The retire counter is inline.

Verification
REQ-034 Reset release, in_start with in_type=0 -> cnt 1,2,3,4,0 on consecutive cycles; out_en=5'b00001 for 5 cycles; out_done at cnt=0; out_retired=1.
REQ-035 in_type=2, in_stall high 3 cycles at cnt=2 -> cnt holds at 2 for 3 cycles; retire at the 8th cycle after start.
REQ-036 in_type=6 in IDLE -> out_illegal pulse for 1 cycle; out_en=0; out_busy=0.
REQ-037 in_flush at cnt==4 -> next cycle IDLE with no out_done and out_retired unchanged; second in_start in the same RUN is ignored.
REQ-038 Set RETIRE_W=4 and retire 16 instructions -> out_retired wraps to 0.
REQ-039 in_rst asserted at cnt=3 -> all outputs 0 immediately; a new in_start after release begins at cnt=1.

Source files
------------

// File: rtl/switch_mcu_pkg.sv
// Shared definitions for the MCU execute sequencer: instruction classes,
// FSM state encodings and the default length of the execute phase.
package switch_mcu_pkg;

   // Instruction classes as decoded upstream; encodings 5..7 are illegal
   typedef enum logic [2:0] {
      TYPE_RTYPE  = 3'd0,
      TYPE_ITYPE  = 3'd1,
      TYPE_LOAD   = 3'd2,
      TYPE_STORE  = 3'd3,
      TYPE_BRANCH = 3'd4
   } instr_type_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   localparam int unsigned DEFAULT_LAST_CYCLE = 4;
   localparam int unsigned NUM_UNITS          = 5;

   // True for instruction classes that have an execute unit behind them
   function automatic logic is_legal_type(input logic [2:0] t);
      return (t <= 3'(TYPE_BRANCH));
   endfunction

   // True when at most one bit of an execute-enable vector is set
   function automatic logic at_most_one_hot(input logic [NUM_UNITS-1:0] v);
      return ((v & (v - 5'd1)) == 5'd0);
   endfunction

endpackage

// File: rtl/switch_mcu_ex_seq.sv
// Execute-phase sequencer: on a decoded instruction it enables one execute
// unit, broadcasts a cycle number 1..LAST_CYCLE (freezable by a bus stall),
// then retires the instruction and counts it. A flush aborts at any point.
module switch_mcu_ex_seq
   import switch_mcu_pkg::*;
#(
   parameter int unsigned LAST_CYCLE = DEFAULT_LAST_CYCLE,
   parameter int unsigned RETIRE_W   = 16
) (
   input  logic                in_clk,
   input  logic                in_rst,
   input  logic                in_start,
   input  logic [2:0]          in_type,
   input  logic                in_stall,
   input  logic                in_flush,
   output logic [3:0]          out_cycle_cnt,
   output logic [4:0]          out_en,
   output logic                out_busy,
   output logic                out_done,
   output logic                out_illegal,
   output logic [RETIRE_W-1:0] out_retired
);

   localparam logic [3:0] LAST_CNT = 4'(LAST_CYCLE);

   seq_state_e          state;
   seq_state_e          next_state;
   logic [3:0]          cnt_nxt;
   logic [4:0]          en_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic                illegal_nxt;
   logic [RETIRE_W-1:0] retired_nxt;

   // State register; reset drops straight back to IDLE
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection; flush overrides every other condition
   always_comb begin
      next_state = state;
      if (in_flush) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_start && is_legal_type(in_type)) begin
                  next_state = ST_RUN;
               end else begin
                  next_state = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (!in_stall && (out_cycle_cnt == LAST_CNT)) begin
                  next_state = ST_DONE;
               end else begin
                  next_state = ST_RUN;
               end
            end
            ST_DONE: begin
               next_state = ST_IDLE;
            end
            default: begin
               next_state = ST_IDLE;
            end
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      cnt_nxt     = out_cycle_cnt;
      en_nxt      = out_en;
      done_nxt    = 1'b0;
      illegal_nxt = 1'b0;
      retired_nxt = out_retired;
      if (in_flush) begin
         cnt_nxt = 4'd0;
         en_nxt  = 5'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt_nxt = 4'd0;
               en_nxt  = 5'd0;
               if (in_start) begin
                  if (is_legal_type(in_type)) begin
                     cnt_nxt = 4'd1;
                     en_nxt  = 5'd1 << in_type;
                  end else begin
                     illegal_nxt = 1'b1;
                  end
               end else begin
                  illegal_nxt = 1'b0;
               end
            end
            ST_RUN: begin
               if (in_stall) begin
                  cnt_nxt = out_cycle_cnt;
               end else if (out_cycle_cnt == LAST_CNT) begin
                  // Retire: unit enable stays up through DONE
                  cnt_nxt  = 4'd0;
                  done_nxt = 1'b1;
               end else begin
                  cnt_nxt = out_cycle_cnt + 4'd1;
               end
            end
            ST_DONE: begin
               cnt_nxt     = 4'd0;
               en_nxt      = 5'd0;
               retired_nxt = out_retired + RETIRE_W'(1);
            end
            default: begin
               cnt_nxt = 4'd0;
               en_nxt  = 5'd0;
            end
         endcase
      end
      busy_nxt = (next_state != ST_IDLE);
   end

   // Output registers
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         out_cycle_cnt <= 4'd0;
         out_en        <= 5'd0;
         out_busy      <= 1'b0;
         out_done      <= 1'b0;
         out_illegal   <= 1'b0;
         out_retired   <= '0;
      end else begin
         out_cycle_cnt <= cnt_nxt;
         out_en        <= en_nxt;
         out_busy      <= busy_nxt;
         out_done      <= done_nxt;
         out_illegal   <= illegal_nxt;
         out_retired   <= retired_nxt;
      end
   end

endmodule

// File: tb/tb_switch_mcu_ex_seq.sv
// Directed bench for the execute sequencer (LAST_CYCLE=4, RETIRE_W=4).
module tb_switch_mcu_ex_seq;

   logic       in_clk;
   logic       in_rst;
   logic       in_start;
   logic [2:0] in_type;
   logic       in_stall;
   logic       in_flush;
   logic [3:0] out_cycle_cnt;
   logic [4:0] out_en;
   logic       out_busy;
   logic       out_done;
   logic       out_illegal;
   logic [3:0] out_retired;

   int checks   = 0;
   int failures = 0;
   logic [3:0] exp_ret;
   logic [4:0] exp_en;

   switch_mcu_ex_seq #(.LAST_CYCLE(4), .RETIRE_W(4)) dut (
      .in_clk        (in_clk),
      .in_rst        (in_rst),
      .in_start      (in_start),
      .in_type       (in_type),
      .in_stall      (in_stall),
      .in_flush      (in_flush),
      .out_cycle_cnt (out_cycle_cnt),
      .out_en        (out_en),
      .out_busy      (out_busy),
      .out_done      (out_done),
      .out_illegal   (out_illegal),
      .out_retired   (out_retired)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] cnt, input logic [4:0] en,
                          input logic busy, input logic done, input logic ill,
                          input logic [3:0] ret);
      chk({tag, ".cnt"},     32'(out_cycle_cnt), 32'(cnt));
      chk({tag, ".en"},      32'(out_en),        32'(en));
      chk({tag, ".busy"},    32'(out_busy),      32'(busy));
      chk({tag, ".done"},    32'(out_done),      32'(done));
      chk({tag, ".illegal"}, 32'(out_illegal),   32'(ill));
      chk({tag, ".retired"}, 32'(out_retired),   32'(ret));
   endtask

   initial begin
      in_rst = 1'b0; in_start = 1'b0; in_type = 3'd0; in_stall = 1'b0; in_flush = 1'b0;
      exp_ret = 4'd0;

      // Reset state
      tick(); tick();
      chk_all("reset", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);

      // R-type right after release: cnt 1,2,3,4,0 then back to IDLE
      in_rst = 1'b1; in_start = 1'b1; in_type = 3'd0;
      tick(); in_start = 1'b0;
      chk_all("r.c1", 4'd1, 5'b00001, 1'b1, 1'b0, 1'b0, 4'd0);
      tick(); chk_all("r.c2", 4'd2, 5'b00001, 1'b1, 1'b0, 1'b0, 4'd0);
      tick(); chk_all("r.c3", 4'd3, 5'b00001, 1'b1, 1'b0, 1'b0, 4'd0);
      tick(); chk_all("r.c4", 4'd4, 5'b00001, 1'b1, 1'b0, 1'b0, 4'd0);
      tick(); chk_all("r.done", 4'd0, 5'b00001, 1'b1, 1'b1, 1'b0, 4'd0);
      tick(); exp_ret = 4'd1;
      chk_all("r.idle", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);

      // Load with a 3-cycle stall at cnt=2; retire on the 8th edge
      in_start = 1'b1; in_type = 3'd2;
      tick(); in_start = 1'b0;
      chk_all("ld.c1", 4'd1, 5'b00100, 1'b1, 1'b0, 1'b0, exp_ret);
      tick(); chk_all("ld.c2", 4'd2, 5'b00100, 1'b1, 1'b0, 1'b0, exp_ret);
      in_stall = 1'b1;
      tick(); chk_all("ld.st1", 4'd2, 5'b00100, 1'b1, 1'b0, 1'b0, exp_ret);
      tick(); chk_all("ld.st2", 4'd2, 5'b00100, 1'b1, 1'b0, 1'b0, exp_ret);
      tick(); chk_all("ld.st3", 4'd2, 5'b00100, 1'b1, 1'b0, 1'b0, exp_ret);
      in_stall = 1'b0;
      tick(); chk_all("ld.c3", 4'd3, 5'b00100, 1'b1, 1'b0, 1'b0, exp_ret);
      tick(); chk_all("ld.c4", 4'd4, 5'b00100, 1'b1, 1'b0, 1'b0, exp_ret);
      tick(); chk_all("ld.done", 4'd0, 5'b00100, 1'b1, 1'b1, 1'b0, exp_ret);
      tick(); exp_ret = 4'd2;
      chk_all("ld.idle", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);

      // Illegal type in IDLE: one-cycle pulse, nothing enabled
      in_start = 1'b1; in_type = 3'd6;
      tick(); in_start = 1'b0;
      chk_all("ill.pulse", 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, exp_ret);
      tick(); chk_all("ill.after", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);

      // I-type, second start ignored, flush at cnt==LAST_CYCLE
      in_start = 1'b1; in_type = 3'd1;
      tick(); in_type = 3'd3;
      chk_all("fl.c1", 4'd1, 5'b00010, 1'b1, 1'b0, 1'b0, exp_ret);
      tick(); in_start = 1'b0;
      chk_all("fl.c2", 4'd2, 5'b00010, 1'b1, 1'b0, 1'b0, exp_ret);
      tick(); tick();
      chk_all("fl.c4", 4'd4, 5'b00010, 1'b1, 1'b0, 1'b0, exp_ret);
      in_flush = 1'b1;
      tick(); in_flush = 1'b0;
      chk_all("fl.idle", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);
      tick(); chk_all("fl.quiet", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);

      // Flush beats stall
      in_start = 1'b1; in_type = 3'd4;
      tick(); in_start = 1'b0;
      chk_all("fs.c1", 4'd1, 5'b10000, 1'b1, 1'b0, 1'b0, exp_ret);
      in_stall = 1'b1; in_flush = 1'b1;
      tick(); in_stall = 1'b0; in_flush = 1'b0;
      chk_all("fs.idle", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);

      // Flush in DONE suppresses the retire count
      in_start = 1'b1; in_type = 3'd3;
      tick(); in_start = 1'b0;
      tick(); tick(); tick(); tick();
      chk_all("fd.done", 4'd0, 5'b01000, 1'b1, 1'b1, 1'b0, exp_ret);
      in_flush = 1'b1;
      tick(); in_flush = 1'b0;
      chk_all("fd.idle", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);

      // Asynchronous reset at cnt=3
      in_start = 1'b1; in_type = 3'd3;
      tick(); in_start = 1'b0;
      tick(); tick();
      chk_all("ar.c3", 4'd3, 5'b01000, 1'b1, 1'b0, 1'b0, exp_ret);
      #2 in_rst = 1'b0;
      #1 exp_ret = 4'd0;
      chk_all("ar.async", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);
      tick();
      chk_all("ar.held", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);
      in_rst = 1'b1; in_start = 1'b1; in_type = 3'd0;
      tick(); in_start = 1'b0;
      chk_all("ar.c1", 4'd1, 5'b00001, 1'b1, 1'b0, 1'b0, exp_ret);
      tick(); tick(); tick(); tick(); tick();
      exp_ret = 4'd1;
      chk_all("ar.ret", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ret);

      // Back-to-back retires with start held high: period 6, counter wraps
      in_start = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_type = 3'(i % 5);
         exp_en  = 5'd1 << in_type;
         tick();
         chk("bb.c1", 32'(out_cycle_cnt), 32'd1);
         chk("bb.en", 32'(out_en), 32'(exp_en));
         tick(); tick(); tick(); tick();
         chk("bb.done", 32'(out_done), 32'd1);
         tick();
         exp_ret = exp_ret + 4'd1;
         chk("bb.busy", 32'(out_busy), 32'd0);
         chk("bb.ret", 32'(out_retired), 32'(exp_ret));
         if (i == 14) begin
            chk("bb.wrap", 32'(out_retired), 32'd0);
         end
      end
      in_start = 1'b0;
      tick();
      chk_all("bb.end", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
